// File: rtl/promediador_coherente_if.sv
// Handshake and data bundle for the coherent averager.
// master drives samples/start; slave is the averager.
interface promediador_coherente_if #(
  parameter int DW = 27,
  parameter int N  = 8,
  parameter int M  = 16
);
  localparam int AW = DW + $clog2(M);
  localparam int IW = $clog2(N);

  logic          start;
  logic          data_valid;
  logic [DW-1:0] data_in;
  logic          busy;
  logic [AW-1:0] data_out;
  logic          data_out_valid;
  logic [IW-1:0] data_out_index;
  logic          done;

  modport master (
    output start,
    output data_valid,
    output data_in,
    input  busy,
    input  data_out,
    input  data_out_valid,
    input  data_out_index,
    input  done
  );

  modport slave (
    input  start,
    input  data_valid,
    input  data_in,
    output busy,
    output data_out,
    output data_out_valid,
    output data_out_index,
    output done
  );
endinterface

// File: rtl/promediador_coherente.sv
// Coherent averager: sums M periods of an N-point stream
// point by point, then streams out the N per-point sums.
module promediador_coherente #(
  parameter int DW = 27,
  parameter int N  = 8,
  parameter int M  = 16
) (
  input logic                    clk,
  input logic                    reset,
  promediador_coherente_if.slave bus
);
  localparam int AW = DW + $clog2(M);
  localparam int IW = $clog2(N);
  localparam int PW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DUMP
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [PW-1:0] per_q;
  logic [AW-1:0] buf_q [N];
  logic          busy_q;
  logic [AW-1:0] dout_q;
  logic          dvalid_q;
  logic [IW-1:0] didx_q;
  logic          done_q;

  logic          take_d;
  logic          last_idx_d;
  logic          last_per_d;
  logic [AW-1:0] sum_d;
  logic [IW-1:0] nxt_d;

  // Sample acceptance, wrap detection and the RMW sum.
  // First period overwrites, so stale data never leaks.
  always_comb begin
    take_d     = (state_q == ACCUM) && bus.data_valid;
    last_idx_d = (idx_q == IW'(N - 1));
    last_per_d = (per_q == PW'(M - 1));
    nxt_d      = didx_q + IW'(1);
    if (per_q == '0)
      sum_d = AW'(bus.data_in);
    else
      sum_d = buf_q[idx_q] + AW'(bus.data_in);
  end

  // Point buffer; no reset, the first period rewrites it.
  always_ff @(posedge clk) begin
    if (!reset && take_d)
      buf_q[idx_q] <= sum_d;
  end

  // Run control with registered outputs.
  // Word 0 is loaded on the last accepted sample so the
  // dump starts the very next cycle; buf_q[0] is already
  // final then because N >= 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      per_q    <= '0;
      busy_q   <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      didx_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ACCUM;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            per_q   <= '0;
          end
        end
        ACCUM: begin
          if (bus.data_valid) begin
            if (last_idx_d) begin
              idx_q <= '0;
              per_q <= per_q + PW'(1);
              if (last_per_d) begin
                state_q  <= DUMP;
                dout_q   <= buf_q[0];
                didx_q   <= '0;
                dvalid_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        DUMP: begin
          if (didx_q == IW'(N - 1)) begin
            state_q  <= IDLE;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            dout_q <= buf_q[nxt_d];
            didx_q <= nxt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dvalid_q;
  assign bus.data_out_index = didx_q;
  assign bus.done           = done_q;
endmodule

// File: doc/promediador_coherente.md
# promediador_coherente

Coherent-averaging accumulator for the lock-in chain. It accumulates M consecutive periods of an N-point periodic sample stream point-by-point into an internal buffer, then streams out the N per-point sums. It sits directly downstream of the registered two-operand adder stage and consumes its widened output (Q1+1 bits).

## Interface

Parameters:
- `DW`, 27: input sample width; unsigned; matches the adder output width.
- `N`, 8: points per period; ≥2.
- `M`, 16: periods accumulated per run; ≥1.
- `AW`, DW+$clog2(M) (derived, localparam): accumulator/output width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run; ignored while `busy`=1.
- `data_valid`  in  1  qualifies `data_in`.
- `data_in`  in  DW  sample, unsigned.
- `busy`  out  1  high from the cycle after an accepted `start` through the last output cycle.
- `data_out`  out  AW  per-point sum.
- `data_out_valid`  out  1  qualifies `data_out`/`data_out_index`.
- `data_out_index`  out  $clog2(N)  point index of `data_out`.
- `done`  out  1  one-cycle pulse after the last output word.

## Operation

- States: IDLE, ACCUM, DUMP.
- IDLE: `busy`=0. `start`=1 → ACCUM; point index `idx`=0 and period counter `per`=0.
- ACCUM: each cycle with `data_valid`=1 accepts one sample:
  - When `per`=0, `buf[idx] <= data_in` (overwrite, so there is no separate clear pass).
  - Otherwise, `buf[idx] <= buf[idx] + data_in`, zero-extended to AW.
  - `idx` increments, wrapping from N-1 to 0. On that wrap, `per` increments.
  - Accepting sample idx=N-1 with `per`=M-1 → DUMP, with output pointer `op`=0.
- Cycles with `data_valid`=0 do not advance any state. Gaps of any length are allowed.
- DUMP:
  - Each cycle, `data_out=buf[op]`, `data_out_index=op` and `data_out_valid=1`, for `op`=0..N-1.
  - After `op`=N-1: `done`=1 for one cycle, `busy`=0, then IDLE.
  - `data_valid` is ignored in DUMP and IDLE.
- Arithmetic: unsigned. AW bits hold M·(2^DW−1) exactly; overflow cannot occur.
- `start` while `busy`=1 is ignored and does not restart the run.
- Reset:
  - `reset`=1 at any edge forces IDLE. `idx`, `per` and `op` = 0. `busy`, `data_out_valid` and `done` = 0. `data_out` = 0. `data_out_index` = 0.
  - Buffer contents are not reset. This needs no reset because the first period overwrites them.
  - A reset during ACCUM or DUMP aborts the run with no `done` pulse.

## Timing

- `start` sampled at edge t → `busy`=1 and ACCUM from t+1. A sample with `data_valid` at t+1 is accepted as idx 0.
- Read-modify-write completes in one cycle per sample. Back-to-back valid samples at the same idx are impossible, since N≥2.
- The last sample accepted at edge t → DUMP from t+1. The word for `op`=k is valid in cycle t+1+k.
- `done` is high in cycle t+1+N, with `data_out_valid`=0 and `busy`=0 in that same cycle.
- A new `start` is accepted from cycle t+1+N onward, i.e. at the `done` cycle or later.
- Outputs are registered. `data_out` holds its last value when `data_out_valid`=0.
- Total run length with no gaps: 1 + N·M + N + 1 cycles from `start` to the end of `done`.

## Test plan

Conditions for all scenarios: N=4, M=3, DW=8, AW=10.

- Constant input. `start`, then 12 back-to-back samples of value 10 → `data_out` = 30,30,30,30 on indices 0..3 in consecutive cycles. `done` is high one cycle after index 3.
- Ramp pattern. Sample value = idx+1, repeated for 3 periods → outputs 3,6,9,12. This verifies index alignment and idx wrap.
- Full scale. All 12 samples = 255 → every output = 765, with no truncation.
- Valid gaps. Constant 10 with 0–5 random idle cycles between samples, plus `start` pulses injected mid-run → outputs 30×4, exactly one `done`, and the run is not restarted.
- Back-to-back runs. Run 1 with constant 200, then `start` in the `done` cycle and run 2 with constant 1 → run 2 outputs 3,3,3,3. This confirms the first-period overwrite with no stale data.
- Reset mid-operation.
  - `reset` after 5 accepted samples → next cycle `busy`=0, `data_out_valid`=0, no `done`.
  - Then `start` and constant 2 → outputs 6,6,6,6.
  - `reset` asserted during DUMP at `op`=1 → `data_out_valid` drops next cycle and no `done` occurs.
